i2c_slave_responder: RTL and testbench
======================================

Name: i2c_slave_responder

Overview:
Synthesizable single-address I2C slave responder, clocked from the system clock, that oversamples an open-drain SCL/SDA pair. It detects START and STOP conditions and matches a 7-bit device address. It ACKs and collects write bytes, and serves read bytes from a host-side data port. Completed transfers (address, op, bytes) are reported to the host logic that checks I2C traffic from the IICMB Wishbone controller.

Parameters:
I2C_ADDR_WIDTH, 7, device address width
I2C_DATA_WIDTH, 8, bits per data byte
I2C_DEVICE_ADDR, 7'h22, address this slave ACKs

Ports:
clk_i  in  1  system clock; must be ≥10x SCL frequency
rst_i  in  1  reset, asynchronous, active-low
scl_i  in  1  I2C clock as seen on the bus
sda_i  in  1  I2C data as seen on the bus
sda_oe_o  out  1  1 = pull SDA low (open-drain); 0 = release
start_o  out  1  one-cycle pulse on START or repeated START
addr_o  out  I2C_ADDR_WIDTH  address of current transfer, held until next START
op_o  out  1  0 = write, 1 = read; held with addr_o
byte_valid_o  out  1  one-cycle pulse when a write byte has been received
byte_o  out  I2C_DATA_WIDTH  received write byte, valid with byte_valid_o
rd_req_o  out  1  one-cycle pulse when the next read byte is needed
rd_data_i  in  I2C_DATA_WIDTH  read byte; sampled 1 clk after rd_req_o
done_o  out  1  one-cycle pulse when a matched transfer ends (STOP or repeated START)
count_o  out  8  bytes transferred in current/last transfer; saturates at 255

Behaviour:
- Reset (rst_i low, async): all outputs 0, sda_oe_o = 0, FSM = IDLE, count_o = 0.
- Input conditioning:
  - scl_i and sda_i each pass through a 2-FF synchronizer plus one history register.
  - Edge detection uses the synchronized values, so edges are seen 3 clk after the pins change.
- START: synchronized SDA falls while SCL is high. STOP: SDA rises while SCL is high. Both are recognized in every state.
- START handling:
  - Pulse start_o; clear the shift register and count_o; go to ADDR.
  - If a matched transfer was active, pulse done_o in the same cycle as start_o.
- STOP handling: if a matched transfer was active, pulse done_o; go to IDLE; release SDA.
- Data bits are sampled on the SCL rising edge, MSB first. SDA is driven or released only on the SCL falling edge.
- FSM states and transitions:
  - IDLE: wait for START.
  - ADDR: shift 8 bits (7 address + R/W).
    - Match: latch addr_o and op_o; go to ADDR_ACK.
    - Mismatch: go to IGNORE and never drive SDA.
  - ADDR_ACK: assert sda_oe_o on the SCL falling edge after bit 8; release it on the next SCL falling edge.
    - op = 0: go to WR_DATA.
    - op = 1: pulse rd_req_o at the ACK-release fall, load rd_data_i, go to RD_DATA.
  - WR_DATA: shift 8 bits. After the 8th rising edge, pulse byte_valid_o with byte_o, increment count_o, go to WR_ACK.
  - WR_ACK: ACK exactly as in ADDR_ACK; return to WR_DATA.
  - RD_DATA:
    - On each SCL falling edge, drive sda_oe_o = ~bit, MSB first. The first bit is driven at the same fall that releases the address ACK.
    - After bit 8, release SDA at the next fall, increment count_o, go to RD_ACK.
  - RD_ACK: sample master ACK on the SCL rising edge.
    - Low (ACK): pulse rd_req_o, load the next byte at the following fall, go to RD_DATA.
    - High (NACK): go to IGNORE.
  - IGNORE: SDA released; wait for START or STOP.
- The slave never stretches SCL.
- Bytes are always transferred whole; a START or STOP mid-byte discards the partial byte.

Decomposition:
- Package i2c_slave_pkg holds:
  - typedef enum state_t {IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE};
  - typedef enum logic {I2C_WRITE = 0, I2C_READ = 1} i2c_op_t.
- Sub-module i2c_line_sync: 2-FF synchronizer plus rise/fall/START/STOP detection for the SCL/SDA pair. The FSM and shifter stay in the top.

Test Plan:
- Write: START, 0x44 (addr 0x22, W), 0x78, STOP.
  - sda_oe_o high during both ACK slots.
  - byte_valid_o with byte_o = 0x78.
  - done_o with addr_o = 0x22, op_o = 0, count_o = 1.
- Multi-byte write 0x44, 0xA5, 0x3C, STOP: two byte_valid_o pulses in order, count_o = 2, three ACKs.
- Mismatch: START, 0x46 (addr 0x23), 0x78, STOP: sda_oe_o never asserted; no byte_valid_o or done_o; start_o pulses.
- Read: START, 0x45, rd_data_i = 0xA5.
  - SDA shows 1,0,1,0,0,1,0,1.
  - Master ACK produces a second rd_req_o; serve 0x0F, master NACKs, then STOP.
  - done_o with op_o = 1, count_o = 2.
- Repeated START: write 0x44, 0x11, then START, 0x45 read. done_o and start_o pulse in the same cycle; op_o flips to 1.
- Reset mid-ACK: drop rst_i while sda_oe_o = 1. sda_oe_o goes 0 immediately (async); the FSM ignores bits until the next START.

Source files
------------

// File: rtl/i2c_slave_pkg.sv
// Shared types for the I2C slave responder: FSM states and transfer direction.
package i2c_slave_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    IGNORE
  } state_t;

  typedef enum logic {
    I2C_WRITE = 1'b0,
    I2C_READ  = 1'b1
  } i2c_op_t;

  localparam int COUNT_W = 8;

endpackage

// File: rtl/i2c_slave_responder_if.sv
// Bus-side and host-side signals of the I2C slave responder, grouped with modports.
interface i2c_slave_responder_if #(
  parameter int I2C_ADDR_WIDTH = 7,
  parameter int I2C_DATA_WIDTH = 8
);

  logic                      scl_i;
  logic                      sda_i;
  logic                      sda_oe_o;
  logic                      start_o;
  logic [I2C_ADDR_WIDTH-1:0] addr_o;
  logic                      op_o;
  logic                      byte_valid_o;
  logic [I2C_DATA_WIDTH-1:0] byte_o;
  logic                      rd_req_o;
  logic [I2C_DATA_WIDTH-1:0] rd_data_i;
  logic                      done_o;
  logic [7:0]                count_o;

  modport slave (
    input  scl_i, sda_i, rd_data_i,
    output sda_oe_o, start_o, addr_o, op_o, byte_valid_o, byte_o,
           rd_req_o, done_o, count_o
  );

  modport master (
    output scl_i, sda_i, rd_data_i,
    input  sda_oe_o, start_o, addr_o, op_o, byte_valid_o, byte_o,
           rd_req_o, done_o, count_o
  );

endinterface

// File: rtl/i2c_line_sync.sv
// Synchronizes SCL/SDA into the system clock and flags SCL edges and START/STOP.
module i2c_line_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop
);

  logic r_scl_s1, r_scl_s2, r_scl_h;
  logic r_sda_s1, r_sda_s2, r_sda_h;

  // Idle bus is high, so reset to 1 to avoid phantom edges after reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_scl_s1 <= 1'b1;
      r_scl_s2 <= 1'b1;
      r_scl_h  <= 1'b1;
      r_sda_s1 <= 1'b1;
      r_sda_s2 <= 1'b1;
      r_sda_h  <= 1'b1;
    end else begin
      r_scl_s1 <= i_scl;
      r_scl_s2 <= r_scl_s1;
      r_scl_h  <= r_scl_s2;
      r_sda_s1 <= i_sda;
      r_sda_s2 <= r_sda_s1;
      r_sda_h  <= r_sda_s2;
    end
  end

  assign o_sda      = r_sda_s2;
  assign o_scl_rise =  r_scl_s2 & ~r_scl_h;
  assign o_scl_fall = ~r_scl_s2 &  r_scl_h;
  assign o_start    = r_scl_s2 & r_scl_h & ~r_sda_s2 &  r_sda_h;
  assign o_stop     = r_scl_s2 & r_scl_h &  r_sda_s2 & ~r_sda_h;

endmodule

// File: rtl/i2c_slave_responder.sv
// Single-address I2C slave: ACKs its address, collects write bytes, serves read bytes.
module i2c_slave_responder
  import i2c_slave_pkg::*;
#(
  parameter int                      I2C_ADDR_WIDTH  = 7,
  parameter int                      I2C_DATA_WIDTH  = 8,
  parameter logic [I2C_ADDR_WIDTH-1:0] I2C_DEVICE_ADDR = 7'h22
) (
  input logic                  clk_i,
  input logic                  rst_i,
  i2c_slave_responder_if.slave bus
);

  localparam int DW = I2C_DATA_WIDTH;
  localparam int AW = I2C_ADDR_WIDTH;

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

  logic w_sda, w_scl_rise, w_scl_fall, w_start_cond, w_stop_cond;

  i2c_line_sync u_sync (
    .i_clk      (clk_i),
    .i_rst_n    (rst_i),
    .i_scl      (bus.scl_i),
    .i_sda      (bus.sda_i),
    .o_sda      (w_sda),
    .o_scl_rise (w_scl_rise),
    .o_scl_fall (w_scl_fall),
    .o_start    (w_start_cond),
    .o_stop     (w_stop_cond)
  );

  state_t               r_state, w_state;
  logic [3:0]           r_bit_cnt, w_bit_cnt;
  logic [DW-1:0]        r_shift, w_shift, w_shift_in;
  logic [AW-1:0]        r_addr, w_addr;
  i2c_op_t              r_op, w_op;
  logic [DW-1:0]        r_byte, w_byte;
  logic [COUNT_W-1:0]   r_count, w_count;
  logic r_bv, w_bv, r_start, w_start, r_done, w_done, r_rd_req, w_rd_req;
  logic r_sda_oe, w_sda_oe, r_active, w_active, r_ack_drv, w_ack_drv, r_pend, w_pend;

  assign w_shift_in = {r_shift[DW-2:0], w_sda};

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state   <= IDLE;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_addr    <= '0;
      r_op      <= I2C_WRITE;
      r_byte    <= '0;
      r_count   <= '0;
      r_bv      <= 1'b0;
      r_start   <= 1'b0;
      r_done    <= 1'b0;
      r_rd_req  <= 1'b0;
      r_sda_oe  <= 1'b0;
      r_active  <= 1'b0;
      r_ack_drv <= 1'b0;
      r_pend    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_bit_cnt <= w_bit_cnt;
      r_shift   <= w_shift;
      r_addr    <= w_addr;
      r_op      <= w_op;
      r_byte    <= w_byte;
      r_count   <= w_count;
      r_bv      <= w_bv;
      r_start   <= w_start;
      r_done    <= w_done;
      r_rd_req  <= w_rd_req;
      r_sda_oe  <= w_sda_oe;
      r_active  <= w_active;
      r_ack_drv <= w_ack_drv;
      r_pend    <= w_pend;
    end
  end

  always_comb begin
    w_state   = r_state;
    w_bit_cnt = r_bit_cnt;
    w_shift   = r_shift;
    w_addr    = r_addr;
    w_op      = r_op;
    w_byte    = r_byte;
    w_count   = r_count;
    w_bv      = 1'b0;
    w_start   = 1'b0;
    w_done    = 1'b0;
    w_rd_req  = 1'b0;
    w_sda_oe  = r_sda_oe;
    w_active  = r_active;
    w_ack_drv = r_ack_drv;
    w_pend    = r_pend;

    if (w_start_cond) begin
      w_start   = 1'b1;
      w_done    = r_active;
      w_active  = 1'b0;
      w_shift   = '0;
      w_count   = '0;
      w_bit_cnt = '0;
      w_sda_oe  = 1'b0;
      w_ack_drv = 1'b0;
      w_pend    = 1'b0;
      w_state   = ADDR;
    end else if (w_stop_cond) begin
      w_done    = r_active;
      w_active  = 1'b0;
      w_sda_oe  = 1'b0;
      w_ack_drv = 1'b0;
      w_pend    = 1'b0;
      w_state   = IDLE;
    end else begin
      case (r_state)
        ADDR: if (w_scl_rise) begin
          w_shift   = w_shift_in;
          w_bit_cnt = r_bit_cnt + 4'd1;
          if (r_bit_cnt == 4'd7) begin
            if (w_shift_in[DW-1 -: AW] == I2C_DEVICE_ADDR) begin
              w_addr   = w_shift_in[DW-1 -: AW];
              w_op     = i2c_op_t'(w_shift_in[0]);
              w_active = 1'b1;
              w_state  = ADDR_ACK;
            end else begin
              w_state  = IGNORE;
            end
          end
        end
        // First fall after the 8th bit pulls SDA, the next one releases it
        ADDR_ACK, WR_ACK: if (w_scl_fall) begin
          if (!r_ack_drv) begin
            w_sda_oe  = 1'b1;
            w_ack_drv = 1'b1;
          end else begin
            w_sda_oe  = 1'b0;
            w_ack_drv = 1'b0;
            w_bit_cnt = '0;
            if (r_state == WR_ACK || r_op == I2C_WRITE) begin
              w_state = WR_DATA;
            end else begin
              w_rd_req = 1'b1;
              w_pend   = 1'b1;
              w_state  = RD_DATA;
            end
          end
        end
        WR_DATA: if (w_scl_rise) begin
          w_shift   = w_shift_in;
          w_bit_cnt = r_bit_cnt + 4'd1;
          if (r_bit_cnt == 4'd7) begin
            w_bv    = 1'b1;
            w_byte  = w_shift_in;
            w_count = sat_inc(r_count);
            w_state = WR_ACK;
          end
        end
        // The first read bit goes out as soon as the host byte lands, still in SCL low
        RD_DATA: begin
          if (r_pend) begin
            w_pend    = 1'b0;
            w_shift   = bus.rd_data_i;
            w_sda_oe  = ~bus.rd_data_i[DW-1];
            w_bit_cnt = 4'd1;
          end else if (w_scl_fall) begin
            if (r_bit_cnt == 4'd8) begin
              w_sda_oe = 1'b0;
              w_count  = sat_inc(r_count);
              w_state  = RD_ACK;
            end else begin
              w_sda_oe  = ~r_shift[DW-2];
              w_shift   = {r_shift[DW-2:0], 1'b0};
              w_bit_cnt = r_bit_cnt + 4'd1;
            end
          end
        end
        // A fall here can only follow an ACKed rise; a NACK has already left
        RD_ACK: begin
          if (r_pend) begin
            w_pend  = 1'b0;
            w_shift = bus.rd_data_i;
          end else if (w_scl_rise) begin
            if (!w_sda) begin
              w_rd_req = 1'b1;
              w_pend   = 1'b1;
            end else begin
              w_state  = IGNORE;
            end
          end else if (w_scl_fall) begin
            w_sda_oe  = ~r_shift[DW-1];
            w_bit_cnt = 4'd1;
            w_state   = RD_DATA;
          end
        end
        IDLE, IGNORE: ;
        default: w_state = IDLE;
      endcase
    end
  end

  assign bus.sda_oe_o     = r_sda_oe;
  assign bus.start_o      = r_start;
  assign bus.addr_o       = r_addr;
  assign bus.op_o         = r_op;
  assign bus.byte_valid_o = r_bv;
  assign bus.byte_o       = r_byte;
  assign bus.rd_req_o     = r_rd_req;
  assign bus.done_o       = r_done;
  assign bus.count_o      = r_count;

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Directed bench: an I2C master model drives SCL/SDA and each scenario checks the slave inline.
module tb_i2c_slave_responder;

  localparam int Q = 5;

  logic clk   = 1'b0;
  logic rst_i = 1'b0;
  logic m_scl = 1'b1;
  logic m_sda = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;

  i2c_slave_responder_if #(.I2C_ADDR_WIDTH(7), .I2C_DATA_WIDTH(8)) bus ();

  assign bus.scl_i = m_scl;
  assign bus.sda_i = m_sda & ~bus.sda_oe_o;

  i2c_slave_responder dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int         n_start = 0, n_done = 0, n_bv = 0, n_rdreq = 0, n_oe = 0, n_both = 0;
  int         wr_n = 0;
  logic [7:0] wr_log [0:31];
  logic [6:0] d_addr  = '0;
  logic       d_op    = 1'b0;
  logic [7:0] d_count = '0;

  always @(negedge clk) begin
    if (bus.start_o) n_start <= n_start + 1;
    if (bus.done_o) begin
      n_done  <= n_done + 1;
      d_addr  <= bus.addr_o;
      d_op    <= bus.op_o;
      d_count <= bus.count_o;
    end
    if (bus.start_o && bus.done_o) n_both <= n_both + 1;
    if (bus.rd_req_o) n_rdreq <= n_rdreq + 1;
    if (bus.sda_oe_o) n_oe <= n_oe + 1;
    if (bus.byte_valid_o && wr_n < 32) begin
      wr_log[wr_n] <= bus.byte_o;
      wr_n         <= wr_n + 1;
    end
  end

  initial begin
    repeat (50000) @(posedge clk);
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog expired");
  end

  // ---------------- master bus model ----------------
  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; m_scl = 1'b1; wait_q();
    m_sda = 1'b0; wait_q();
    m_scl = 1'b0; wait_q();
  endtask

  task automatic i2c_rstart();
    m_sda = 1'b1; wait_q();
    m_scl = 1'b1; wait_q();
    m_sda = 1'b0; wait_q();
    m_scl = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; wait_q();
    m_scl = 1'b1; wait_q();
    m_sda = 1'b1; wait_q();
    wait_q();
  endtask

  task automatic xfer_bit(input logic b, output logic s);
    m_sda = b; wait_q();
    m_scl = 1'b1; wait_q();
    s = bus.sda_i; wait_q();
    m_scl = 1'b0; wait_q();
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) xfer_bit(d[i], s);
    xfer_bit(1'b1, ack);
  endtask

  task automatic read_byte(output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      xfer_bit(1'b1, s);
      d[i] = s;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_i = 1'b0; bus.rd_data_i = 8'h00;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.sda_oe_o !== 1'b0) begin n_fail++; $display("FAIL reset_sda_oe got=%b exp=0", bus.sda_oe_o); end
    n_checks++; if (bus.start_o !== 1'b0) begin n_fail++; $display("FAIL reset_start got=%b exp=0", bus.start_o); end
    n_checks++; if (bus.done_o !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", bus.done_o); end
    n_checks++; if (bus.byte_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_bv got=%b exp=0", bus.byte_valid_o); end
    n_checks++; if (bus.rd_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_rdreq got=%b exp=0", bus.rd_req_o); end
    n_checks++; if (bus.count_o !== 8'h00) begin n_fail++; $display("FAIL reset_count got=%h exp=00", bus.count_o); end
    n_checks++; if (bus.addr_o !== 7'h00) begin n_fail++; $display("FAIL reset_addr got=%h exp=00", bus.addr_o); end
    n_checks++; if (bus.op_o !== 1'b0) begin n_fail++; $display("FAIL reset_op got=%b exp=0", bus.op_o); end
    n_checks++; if (bus.byte_o !== 8'h00) begin n_fail++; $display("FAIL reset_byte got=%h exp=00", bus.byte_o); end
    rst_i = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_write();
    int s0 = n_start, d0 = n_done, b0 = wr_n;
    logic ack;
    i2c_start();
    write_byte(8'h44, ack);
    n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL wr_addr_ack sda=%b exp=0", ack); end
    write_byte(8'h78, ack);
    n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL wr_data_ack sda=%b exp=0", ack); end
    i2c_stop();
    wait_q(); wait_q();
    n_checks++; if (wr_n - b0 !== 1) begin n_fail++; $display("FAIL wr_bv_count got=%0d exp=1", wr_n - b0); end
    n_checks++; if (wr_log[b0] !== 8'h78) begin n_fail++; $display("FAIL wr_byte got=%h exp=78", wr_log[b0]); end
    n_checks++; if (n_start - s0 !== 1) begin n_fail++; $display("FAIL wr_start got=%0d exp=1", n_start - s0); end
    n_checks++; if (n_done - d0 !== 1) begin n_fail++; $display("FAIL wr_done got=%0d exp=1", n_done - d0); end
    n_checks++; if (d_addr !== 7'h22) begin n_fail++; $display("FAIL wr_done_addr got=%h exp=22", d_addr); end
    n_checks++; if (d_op !== 1'b0) begin n_fail++; $display("FAIL wr_done_op got=%b exp=0", d_op); end
    n_checks++; if (d_count !== 8'd1) begin n_fail++; $display("FAIL wr_done_count got=%0d exp=1", d_count); end
  endtask

  task automatic test_multi_write();
    int d0 = n_done, b0 = wr_n, acks = 0;
    logic ack;
    i2c_start();
    write_byte(8'h44, ack); if (ack == 1'b0) acks++;
    write_byte(8'hA5, ack); if (ack == 1'b0) acks++;
    write_byte(8'h3C, ack); if (ack == 1'b0) acks++;
    i2c_stop();
    wait_q(); wait_q();
    n_checks++; if (acks !== 3) begin n_fail++; $display("FAIL mw_acks got=%0d exp=3", acks); end
    n_checks++; if (wr_n - b0 !== 2) begin n_fail++; $display("FAIL mw_bv_count got=%0d exp=2", wr_n - b0); end
    n_checks++; if (wr_log[b0] !== 8'hA5) begin n_fail++; $display("FAIL mw_byte0 got=%h exp=a5", wr_log[b0]); end
    n_checks++; if (wr_log[b0+1] !== 8'h3C) begin n_fail++; $display("FAIL mw_byte1 got=%h exp=3c", wr_log[b0+1]); end
    n_checks++; if (n_done - d0 !== 1) begin n_fail++; $display("FAIL mw_done got=%0d exp=1", n_done - d0); end
    n_checks++; if (d_count !== 8'd2) begin n_fail++; $display("FAIL mw_count got=%0d exp=2", d_count); end
  endtask

  task automatic test_mismatch();
    int s0 = n_start, d0 = n_done, b0 = wr_n, o0 = n_oe;
    logic ack;
    i2c_start();
    write_byte(8'h46, ack);
    n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL mm_no_ack sda=%b exp=1", ack); end
    write_byte(8'h78, ack);
    i2c_stop();
    wait_q(); wait_q();
    n_checks++; if (n_oe - o0 !== 0) begin n_fail++; $display("FAIL mm_sda_oe cycles=%0d exp=0", n_oe - o0); end
    n_checks++; if (wr_n - b0 !== 0) begin n_fail++; $display("FAIL mm_bv got=%0d exp=0", wr_n - b0); end
    n_checks++; if (n_done - d0 !== 0) begin n_fail++; $display("FAIL mm_done got=%0d exp=0", n_done - d0); end
    n_checks++; if (n_start - s0 !== 1) begin n_fail++; $display("FAIL mm_start got=%0d exp=1", n_start - s0); end
  endtask

  task automatic test_read();
    int d0 = n_done, r0 = n_rdreq;
    logic ack, s;
    logic [7:0] d;
    bus.rd_data_i = 8'hA5;
    i2c_start();
    write_byte(8'h45, ack);
    n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL rd_addr_ack sda=%b exp=0", ack); end
    read_byte(d);
    n_checks++; if (d !== 8'hA5) begin n_fail++; $display("FAIL rd_byte0 got=%h exp=a5", d); end
    bus.rd_data_i = 8'h0F;
    xfer_bit(1'b0, s);
    read_byte(d);
    n_checks++; if (d !== 8'h0F) begin n_fail++; $display("FAIL rd_byte1 got=%h exp=0f", d); end
    xfer_bit(1'b1, s);
    i2c_stop();
    wait_q(); wait_q();
    n_checks++; if (n_rdreq - r0 !== 2) begin n_fail++; $display("FAIL rd_req_count got=%0d exp=2", n_rdreq - r0); end
    n_checks++; if (n_done - d0 !== 1) begin n_fail++; $display("FAIL rd_done got=%0d exp=1", n_done - d0); end
    n_checks++; if (d_op !== 1'b1) begin n_fail++; $display("FAIL rd_done_op got=%b exp=1", d_op); end
    n_checks++; if (d_addr !== 7'h22) begin n_fail++; $display("FAIL rd_done_addr got=%h exp=22", d_addr); end
    n_checks++; if (d_count !== 8'd2) begin n_fail++; $display("FAIL rd_done_count got=%0d exp=2", d_count); end
  endtask

  task automatic test_back_to_back();
    int s0 = n_start, d0 = n_done, b0 = wr_n, p0 = n_both;
    logic ack, s;
    logic [7:0] d;
    bus.rd_data_i = 8'h5A;
    i2c_start();
    write_byte(8'h44, ack);
    write_byte(8'h11, ack);
    n_checks++; if (bus.op_o !== 1'b0) begin n_fail++; $display("FAIL rs_op_before got=%b exp=0", bus.op_o); end
    i2c_rstart();
    write_byte(8'h45, ack);
    n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL rs_addr_ack sda=%b exp=0", ack); end
    n_checks++; if (bus.op_o !== 1'b1) begin n_fail++; $display("FAIL rs_op_after got=%b exp=1", bus.op_o); end
    read_byte(d);
    n_checks++; if (d !== 8'h5A) begin n_fail++; $display("FAIL rs_rd_byte got=%h exp=5a", d); end
    xfer_bit(1'b1, s);
    i2c_stop();
    wait_q(); wait_q();
    n_checks++; if (n_both - p0 !== 1) begin n_fail++; $display("FAIL rs_done_with_start got=%0d exp=1", n_both - p0); end
    n_checks++; if (wr_log[b0] !== 8'h11) begin n_fail++; $display("FAIL rs_wr_byte got=%h exp=11", wr_log[b0]); end
    n_checks++; if (n_start - s0 !== 2) begin n_fail++; $display("FAIL rs_start got=%0d exp=2", n_start - s0); end
    n_checks++; if (n_done - d0 !== 2) begin n_fail++; $display("FAIL rs_done got=%0d exp=2", n_done - d0); end
    n_checks++; if (d_count !== 8'd1) begin n_fail++; $display("FAIL rs_count got=%0d exp=1", d_count); end
  endtask

  task automatic test_reset_mid_ack();
    int s0, d0, b0, o0;
    logic ack, s;
    i2c_start();
    write_byte(8'h44, ack);
    for (int i = 7; i >= 0; i--) xfer_bit(1'(8'h55 >> i), s);
    m_sda = 1'b1; wait_q();
    n_checks++; if (bus.sda_oe_o !== 1'b1) begin n_fail++; $display("FAIL rst_ack_driven got=%b exp=1", bus.sda_oe_o); end
    @(negedge clk);
    rst_i = 1'b0;
    #1;
    n_checks++; if (bus.sda_oe_o !== 1'b0) begin n_fail++; $display("FAIL rst_async_release got=%b exp=0", bus.sda_oe_o); end
    n_checks++; if (bus.count_o !== 8'h00) begin n_fail++; $display("FAIL rst_count got=%h exp=00", bus.count_o); end
    repeat (2) @(negedge clk);
    rst_i = 1'b1;
    m_scl = 1'b1; wait_q(); wait_q();
    m_scl = 1'b0; wait_q();
    s0 = n_start; d0 = n_done; b0 = wr_n; o0 = n_oe;
    write_byte(8'h44, ack);
    n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL rst_ignore_ack sda=%b exp=1", ack); end
    i2c_stop();
    wait_q(); wait_q();
    n_checks++; if (n_oe - o0 !== 0) begin n_fail++; $display("FAIL rst_ignore_oe cycles=%0d exp=0", n_oe - o0); end
    n_checks++; if (wr_n - b0 !== 0) begin n_fail++; $display("FAIL rst_ignore_bv got=%0d exp=0", wr_n - b0); end
    n_checks++; if (n_done - d0 !== 0) begin n_fail++; $display("FAIL rst_ignore_done got=%0d exp=0", n_done - d0); end
    n_checks++; if (n_start - s0 !== 0) begin n_fail++; $display("FAIL rst_ignore_start got=%0d exp=0", n_start - s0); end
    b0 = wr_n; d0 = n_done;
    i2c_start();
    write_byte(8'h44, ack);
    write_byte(8'h99, ack);
    i2c_stop();
    wait_q(); wait_q();
    n_checks++; if (wr_log[b0] !== 8'h99) begin n_fail++; $display("FAIL rst_recover_byte got=%h exp=99", wr_log[b0]); end
    n_checks++; if (n_done - d0 !== 1) begin n_fail++; $display("FAIL rst_recover_done got=%0d exp=1", n_done - d0); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_multi_write();
    test_mismatch();
    test_read();
    test_back_to_back();
    test_reset_mid_ack();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
